lpc_wb_initiator: RTL and testbench
===================================

# lpc_wb_initiator

Wishbone bus initiator driving the FPGA-side register bank from a simple command/response handshake. It sits between the LPC/host command decoder and the existing register-bank responder. It converts one command at a time into a single Wishbone classic cycle and waits for ACK, with a timeout. It returns read data and error status on a response channel held until consumed.

## Interface
- TIMEOUT_CYCLES, 8'd255: cycles in REQ without ACK before abort; legal 2..255.
- ERR_READ_VALUE, 32'hDEFFABAC: rsp_dat_o value on a timed-out transaction.
- WBs_CLK_i  in  1  clock; all logic on rising edge.
- WBs_RST_i  in  1  asynchronous, active-high reset.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  command accepted this cycle when cmd_valid_i also high.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_adr_i  in  17  byte address.
- cmd_dat_i  in  32  write data.
- cmd_sel_i  in  4  byte strobes.
- rsp_valid_o  out  1  response available.
- rsp_ready_i  in  1  response consumed this cycle when rsp_valid_o also high.
- rsp_dat_o  out  32  read data; 0 for writes; ERR_READ_VALUE on timeout.
- rsp_err_o  out  1  transaction timed out.
- WBm_ADR_o  out  17, WBm_DAT_o  out  32, WBm_WE_o  out  1, WBm_BYTE_STB_o  out  4, WBm_CYC_o  out  1, WBm_STB_o  out  1: Wishbone master outputs, all registered.
- WBm_DAT_i  in  32, WBm_ACK_i  in  1: Wishbone responder return.
- busy_o  out  1  high in REQ or RESP.
- err_cnt_o  out  8  saturating count of timed-out transactions.

## Operation
- States: IDLE, REQ, RESP. Reset state is IDLE.
- Reset values: every output 0, except cmd_ready_o = 1 combinationally from IDLE. Timeout counter and err_cnt_o are 0.
- IDLE:
  - cmd_ready_o = 1.
  - On cmd_valid_i: latch adr/dat/we/sel into WBm_* outputs, set CYC_o = STB_o = 1, clear the timeout counter, go to REQ.
- REQ:
  - cmd_ready_o = 0.
  - ADR/DAT/WE/BYTE_STB are held stable for the whole state.
  - The timeout counter (8 bits) increments each cycle ACK_i is low.
  - ACK_i sampled high:
    - CYC_o and STB_o drop on the same edge.
    - rsp_dat_o = cmd_we ? 0 : WBm_DAT_i.
    - rsp_err_o = 0, rsp_valid_o = 1, go to RESP.
  - Timeout: counter == TIMEOUT_CYCLES-1 and ACK_i low.
    - CYC_o and STB_o drop.
    - rsp_dat_o = ERR_READ_VALUE, rsp_err_o = 1, rsp_valid_o = 1.
    - err_cnt_o increments, saturating at 255. Go to RESP.
  - ACK and the timeout condition in the same cycle: ACK wins and no error is reported.
- RESP:
  - rsp_valid_o, rsp_dat_o and rsp_err_o are held until rsp_ready_i.
  - On rsp_ready_i: rsp_valid_o clears, go to IDLE. rsp_dat_o and rsp_err_o keep their last value.
- WBm_WE_o and WBm_BYTE_STB_o are forced to 0 outside REQ. ADR_o and DAT_o hold the last command.
- WBm_ACK_i in IDLE or RESP is ignored: no state change, no response.
- One outstanding transaction only. No pipelining, bursts or retries.
- Reset asserted mid-REQ or mid-RESP: outputs go to 0 immediately (asynchronous) and the in-flight command is dropped with no response.

## Timing
- Accept edge E0: cmd_valid_i && cmd_ready_o. CYC_o and STB_o are high after E0.
- Combinational-ACK responder: ACK sampled at E1. CYC_o and STB_o fall after E1, rsp_valid_o high after E1.
- Registered-ACK responder (ACK = CYC&STB&~ACK, registered):
  - ACK is high after E1 and sampled at E2.
  - CYC_o and STB_o fall after E2, exactly when the responder's ACK falls, so no second ACK pulse occurs.
  - rsp_valid_o is high after E2.
- Timeout abort: rsp_valid_o rises after edge E0+TIMEOUT_CYCLES.
- rsp_ready_i tied high: rsp_valid_o lasts 1 cycle, and cmd_ready_o is 1 the cycle after the consume edge.
- Back-to-back throughput with rsp_ready_i tied high and a registered-ACK responder: one transaction per 4 cycles.

## Test plan
- Write, registered-ACK responder: cmd adr 0x004, dat 0x12345678, sel 0xF, we 1.
  - Expect CYC/STB high exactly 2 cycles with WE = 1 and BYTE_STB = 0xF.
  - Expect rsp_valid_o 2 cycles after accept, rsp_dat_o = 0, rsp_err_o = 0, and the responder register equal to 0x12345678.
- Read back adr 0x004 -> rsp_dat_o = 0x12345678, rsp_err_o = 0, a single ACK pulse observed.
- Partial write sel 0x2, dat 0x0000AB00 to a register holding 0x03000000 -> readback 0x0300AB00.
- No-ACK responder, TIMEOUT_CYCLES = 8.
  - Expect CYC/STB high for 8 cycles and rsp_err_o = 1 with rsp_dat_o = 0xDEFFABAC.
  - Expect err_cnt_o = 1; after 300 such timeouts err_cnt_o = 255.
- Backpressure: hold rsp_ready_i low 5 cycles with cmd_valid_i high.
  - Expect cmd_ready_o = 0 and rsp_* stable throughout.
  - Expect the next command accepted one cycle after the consume edge.
- Assert WBs_RST_i during REQ, then:
  - Expect all outputs 0 immediately.
  - Expect a spurious ACK_i in IDLE produces no rsp_valid_o.
  - Expect the next command to complete normally.

Source files
------------

// File: rtl/lpc_wb_initiator.sv
// Single-outstanding Wishbone classic initiator: one host command becomes one
// bus cycle, finished by ACK or by an ACK timeout, and answered on a held response channel.
module lpc_wb_initiator #(
    parameter logic [7:0]  TIMEOUT_CYCLES = 8'd255,
    parameter logic [31:0] ERR_READ_VALUE = 32'hDEFFABAC
) (
    input  logic        WBs_CLK_i,
    input  logic        WBs_RST_i,

    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [16:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    input  logic [3:0]  cmd_sel_i,

    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,

    output logic [16:0] WBm_ADR_o,
    output logic [31:0] WBm_DAT_o,
    output logic        WBm_WE_o,
    output logic [3:0]  WBm_BYTE_STB_o,
    output logic        WBm_CYC_o,
    output logic        WBm_STB_o,
    input  logic [31:0] WBm_DAT_i,
    input  logic        WBm_ACK_i,

    output logic        busy_o,
    output logic [7:0]  err_cnt_o
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t     state;
    logic [7:0] timeout_cnt;
    logic       timed_out;

    assign cmd_ready_o = (state == IDLE);
    assign busy_o      = (state != IDLE);
    assign timed_out   = (timeout_cnt == (TIMEOUT_CYCLES - 8'd1));

    // NOTE: every state update is non-blocking so all registers see pre-edge values.
    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i) begin
            state          <= IDLE;
            timeout_cnt    <= '0;
            WBm_ADR_o      <= '0;
            WBm_DAT_o      <= '0;
            WBm_WE_o       <= 1'b0;
            WBm_BYTE_STB_o <= '0;
            WBm_CYC_o      <= 1'b0;
            WBm_STB_o      <= 1'b0;
            rsp_valid_o    <= 1'b0;
            rsp_dat_o      <= '0;
            rsp_err_o      <= 1'b0;
            err_cnt_o      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        WBm_ADR_o      <= cmd_adr_i;
                        WBm_DAT_o      <= cmd_dat_i;
                        WBm_WE_o       <= cmd_we_i;
                        WBm_BYTE_STB_o <= cmd_sel_i;
                        WBm_CYC_o      <= 1'b1;
                        WBm_STB_o      <= 1'b1;
                        timeout_cnt    <= '0;
                        state          <= REQ;
                    end
                end
                REQ: begin
                    // ACK is tested first so it wins over a simultaneous timeout.
                    if (WBm_ACK_i) begin
                        WBm_CYC_o      <= 1'b0;
                        WBm_STB_o      <= 1'b0;
                        WBm_WE_o       <= 1'b0;
                        WBm_BYTE_STB_o <= '0;
                        rsp_dat_o      <= WBm_WE_o ? 32'h0 : WBm_DAT_i;
                        rsp_err_o      <= 1'b0;
                        rsp_valid_o    <= 1'b1;
                        state          <= RESP;
                    end else if (timed_out) begin
                        WBm_CYC_o      <= 1'b0;
                        WBm_STB_o      <= 1'b0;
                        WBm_WE_o       <= 1'b0;
                        WBm_BYTE_STB_o <= '0;
                        rsp_dat_o      <= ERR_READ_VALUE;
                        rsp_err_o      <= 1'b1;
                        rsp_valid_o    <= 1'b1;
                        if (err_cnt_o != 8'hFF) begin
                            err_cnt_o <= err_cnt_o + 8'd1;
                        end
                        state          <= RESP;
                    end else begin
                        timeout_cnt <= timeout_cnt + 8'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lpc_wb_initiator.sv
// Bench for lpc_wb_initiator: a configurable Wishbone responder, a latency-based
// transaction model compared on every cycle, and directed scenarios with literal expectations.
module tb_lpc_wb_initiator;

    localparam logic [7:0]  TO   = 8'd8;
    localparam logic [31:0] ERRV = 32'hDEFFABAC;

    // Responder behaviours: registered ACK, combinational ACK, never ACK,
    // ACK exactly on the cycle the initiator would time out.
    typedef enum int {M_REG, M_COMB, M_NONE, M_LATE} ack_mode_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
    logic [16:0] cmd_adr_i;
    logic [31:0] cmd_dat_i;
    logic [3:0]  cmd_sel_i;
    logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
    logic [31:0] rsp_dat_o;
    logic [16:0] WBm_ADR_o;
    logic [31:0] WBm_DAT_o, WBm_DAT_i;
    logic        WBm_WE_o, WBm_CYC_o, WBm_STB_o, WBm_ACK_i;
    logic [3:0]  WBm_BYTE_STB_o;
    logic        busy_o;
    logic [7:0]  err_cnt_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    lpc_wb_initiator #(.TIMEOUT_CYCLES(TO), .ERR_READ_VALUE(ERRV)) dut (
        .WBs_CLK_i(clk), .WBs_RST_i(rst),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i), .cmd_sel_i(cmd_sel_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o),
        .rsp_err_o(rsp_err_o),
        .WBm_ADR_o(WBm_ADR_o), .WBm_DAT_o(WBm_DAT_o), .WBm_WE_o(WBm_WE_o),
        .WBm_BYTE_STB_o(WBm_BYTE_STB_o), .WBm_CYC_o(WBm_CYC_o), .WBm_STB_o(WBm_STB_o),
        .WBm_DAT_i(WBm_DAT_i), .WBm_ACK_i(WBm_ACK_i),
        .busy_o(busy_o), .err_cnt_o(err_cnt_o)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- responder / register bank ----------------
    ack_mode_t   mode = M_REG;
    logic        ack_r;
    logic        ack_force;
    int          late_cnt;
    int          ack_cnt = 0;
    logic [31:0] regs [16] = '{default: 32'h0};
    logic [3:0]  ridx;

    assign ridx      = WBm_ADR_o[5:2];
    assign WBm_DAT_i = regs[ridx];
    assign WBm_ACK_i = ack_force
                     | ((mode == M_REG)  & ack_r)
                     | ((mode == M_COMB) & WBm_CYC_o & WBm_STB_o)
                     | ((mode == M_LATE) & WBm_CYC_o & WBm_STB_o & (late_cnt == int'(TO) - 1));

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_r    <= 1'b0;
            late_cnt <= 0;
        end else begin
            ack_r    <= (mode == M_REG) && WBm_CYC_o && WBm_STB_o && !ack_r;
            late_cnt <= WBm_CYC_o ? late_cnt + 1 : 0;
            ack_cnt  <= ack_cnt + (WBm_ACK_i ? 1 : 0);
            if (WBm_ACK_i && WBm_CYC_o && WBm_STB_o && WBm_WE_o) begin
                for (int b = 0; b < 4; b++) begin
                    if (WBm_BYTE_STB_o[b]) regs[ridx][8*b +: 8] <= WBm_DAT_o[8*b +: 8];
                end
            end
        end
    end

    // ---------------- transaction-level model + per-cycle compare ----------------
    bit          m_busy;
    int          m_age, m_lat;
    logic        m_we, m_next_err, m_rsp_err;
    logic [3:0]  m_sel;
    logic [16:0] m_adr;
    logic [31:0] m_dat, m_next_dat, m_rsp_dat;
    logic [7:0]  m_err_cnt;
    logic [31:0] m_mem [16] = '{default: 32'h0};

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                m_busy = 0; m_age = 0; m_lat = 0; m_we = 0; m_sel = 0;
                m_adr = 0; m_dat = 0; m_rsp_dat = 0; m_rsp_err = 0; m_err_cnt = 0;
            end
            // Bus phase occupies ages 1..lat after acceptance, response phase follows.
            check("cmd_ready", cmd_ready_o, !m_busy);
            check("busy", busy_o, m_busy);
            check("cyc", WBm_CYC_o, m_busy && m_age <= m_lat);
            check("stb", WBm_STB_o, m_busy && m_age <= m_lat);
            check("we", WBm_WE_o, (m_busy && m_age <= m_lat) ? m_we : 1'b0);
            check("byte_stb", WBm_BYTE_STB_o, (m_busy && m_age <= m_lat) ? m_sel : 4'h0);
            check("adr", WBm_ADR_o, m_adr);
            check("dat_o", WBm_DAT_o, m_dat);
            check("rsp_valid", rsp_valid_o, m_busy && m_age > m_lat);
            check("rsp_dat", rsp_dat_o, m_rsp_dat);
            check("rsp_err", rsp_err_o, m_rsp_err);
            check("err_cnt", err_cnt_o, m_err_cnt);
            if (!rst) begin
                if (m_busy) begin
                    if (m_age <= m_lat) begin
                        m_age++;
                        if (m_age > m_lat) begin
                            m_rsp_dat = m_next_dat;
                            m_rsp_err = m_next_err;
                            if (m_next_err && m_err_cnt != 8'd255) m_err_cnt++;
                        end
                    end else if (rsp_ready_i) begin
                        m_busy = 0;
                    end
                end else if (cmd_valid_i) begin
                    m_busy = 1; m_age = 1;
                    m_adr = cmd_adr_i; m_dat = cmd_dat_i; m_we = cmd_we_i; m_sel = cmd_sel_i;
                    m_lat = (mode == M_REG) ? 2 : (mode == M_COMB) ? 1 : int'(TO);
                    m_next_err = (mode == M_NONE);
                    if (m_next_err) begin
                        m_next_dat = ERRV;
                    end else if (cmd_we_i) begin
                        m_next_dat = 32'h0;
                        for (int b = 0; b < 4; b++) begin
                            if (cmd_sel_i[b]) m_mem[cmd_adr_i[5:2]][8*b +: 8] = cmd_dat_i[8*b +: 8];
                        end
                    end else begin
                        m_next_dat = m_mem[cmd_adr_i[5:2]];
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic we, input logic [16:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input ack_mode_t m);
        int guard = 0;
        @(posedge clk); #2;
        mode = m; cmd_valid_i = 1'b1; cmd_we_i = we; cmd_adr_i = adr;
        cmd_dat_i = dat; cmd_sel_i = sel;
        @(negedge clk);
        while (!cmd_ready_o && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("accept_in_time", cmd_ready_o, 1'b1);
        @(posedge clk); #2;
        cmd_valid_i = 1'b0;
    endtask

    // Counts bus-active cycles and edges from acceptance to the response.
    task automatic wait_rsp(output int n_cyc, output int n_edges);
        int k = 0;
        n_cyc = 0;
        while (!rsp_valid_o && k < 600) begin
            @(negedge clk);
            k++;
            if (WBm_CYC_o) n_cyc++;
        end
        check("rsp_arrives", rsp_valid_o, 1'b1);
        n_edges = k - 1;
    endtask

    task automatic consume(input int hold);
        repeat (hold) @(negedge clk);
        @(posedge clk); #2;
        rsp_ready_i = 1'b1;
        @(negedge clk);
        @(posedge clk); #2;
        rsp_ready_i = 1'b0;
    endtask

    task automatic txn(input logic we, input logic [16:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input ack_mode_t m,
                       output logic [31:0] r_dat, output logic r_err,
                       output int n_cyc, output int n_edges);
        issue(we, adr, dat, sel, m);
        wait_rsp(n_cyc, n_edges);
        r_dat = rsp_dat_o;
        r_err = rsp_err_o;
        consume(0);
    endtask

    // ---------------- directed scenarios ----------------
    logic [31:0] d;
    logic        e;
    int          nc, ne, a0, hs, guard;

    initial begin
        cmd_valid_i = 0; cmd_we_i = 0; cmd_adr_i = 0; cmd_dat_i = 0; cmd_sel_i = 0;
        rsp_ready_i = 0; ack_force = 0;
        #1 rst = 1'b1;
        #11;
        check("rst_bus", {WBm_CYC_o, WBm_STB_o, WBm_WE_o, WBm_BYTE_STB_o}, 0);
        check("rst_rsp", {rsp_valid_o, rsp_err_o, busy_o, err_cnt_o}, 0);
        check("rst_cmd_ready", cmd_ready_o, 1'b1);
        @(posedge clk); #2 rst = 1'b0;

        txn(1'b1, 17'h004, 32'h12345678, 4'hF, M_REG, d, e, nc, ne);
        check("wr_cyc_cycles", nc, 2);
        check("wr_rsp_edges", ne, 2);
        check("wr_rsp_dat", d, 32'h0);
        check("wr_rsp_err", e, 1'b0);
        check("wr_reg", regs[1], 32'h12345678);

        a0 = ack_cnt;
        txn(1'b0, 17'h004, 32'h0, 4'hF, M_REG, d, e, nc, ne);
        repeat (3) @(negedge clk);
        check("rd_ack_pulses", ack_cnt - a0, 1);
        check("rd_dat", d, 32'h12345678);
        check("rd_err", e, 1'b0);

        txn(1'b0, 17'h004, 32'h0, 4'hF, M_COMB, d, e, nc, ne);
        check("comb_cyc_cycles", nc, 1);
        check("comb_rsp_edges", ne, 1);
        check("comb_dat", d, 32'h12345678);

        txn(1'b1, 17'h008, 32'h03000000, 4'hF, M_REG, d, e, nc, ne);
        txn(1'b1, 17'h008, 32'h0000AB00, 4'h2, M_REG, d, e, nc, ne);
        txn(1'b0, 17'h008, 32'h0, 4'hF, M_REG, d, e, nc, ne);
        check("partial_dat", d, 32'h0300AB00);

        txn(1'b0, 17'h010, 32'h0, 4'hF, M_NONE, d, e, nc, ne);
        check("to_cyc_cycles", nc, 8);
        check("to_rsp_edges", ne, 8);
        check("to_dat", d, 32'hDEFFABAC);
        check("to_err", e, 1'b1);
        check("to_err_cnt", err_cnt_o, 8'd1);

        txn(1'b0, 17'h004, 32'h0, 4'hF, M_LATE, d, e, nc, ne);
        check("tie_cyc_cycles", nc, 8);
        check("tie_dat", d, 32'h12345678);
        check("tie_err", e, 1'b0);
        check("tie_err_cnt", err_cnt_o, 8'd1);

        // Backpressure: response held 5 cycles while the next command waits.
        @(posedge clk); #2;
        mode = M_REG; cmd_valid_i = 1; cmd_we_i = 1; cmd_adr_i = 17'h00C;
        cmd_dat_i = 32'hA5A55A5A; cmd_sel_i = 4'hF;
        guard = 0;
        @(negedge clk);
        while (!cmd_ready_o && guard < 50) begin @(negedge clk); guard++; end
        @(posedge clk); #2 cmd_we_i = 0;
        wait_rsp(nc, ne);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #2 ack_force = (i == 2);
            @(negedge clk);
            check("bp_cmd_ready", cmd_ready_o, 1'b0);
            check("bp_rsp_valid", rsp_valid_o, 1'b1);
        end
        @(posedge clk); #2 ack_force = 0; rsp_ready_i = 1;
        @(negedge clk);
        @(posedge clk); #2 rsp_ready_i = 0;
        @(negedge clk);
        check("bp_ready_after_consume", cmd_ready_o, 1'b1);
        @(posedge clk); #2 cmd_valid_i = 0;
        @(negedge clk);
        check("bp_next_accepted", WBm_CYC_o, 1'b1);
        wait_rsp(nc, ne);
        check("bp_read_dat", rsp_dat_o, 32'hA5A55A5A);
        consume(0);

        // Throughput with the response side always ready.
        @(posedge clk); #2;
        mode = M_REG; cmd_valid_i = 1; cmd_we_i = 1; cmd_adr_i = 17'h010;
        cmd_dat_i = 32'h0BADBEEF; cmd_sel_i = 4'hF; rsp_ready_i = 1; hs = 0;
        repeat (40) begin
            @(negedge clk);
            if (cmd_valid_i && cmd_ready_o) hs++;
        end
        @(posedge clk); #2 cmd_valid_i = 0; rsp_ready_i = 0;
        check("thru_accepts", hs, 10);
        repeat (2) @(negedge clk);

        repeat (253) txn(1'b1, 17'h014, 32'h1, 4'hF, M_NONE, d, e, nc, ne);
        check("err_cnt_254", err_cnt_o, 8'd254);
        repeat (46) txn(1'b1, 17'h014, 32'h1, 4'hF, M_NONE, d, e, nc, ne);
        check("err_cnt_sat", err_cnt_o, 8'd255);

        // Reset in the middle of a bus cycle.
        issue(1'b1, 17'h004, 32'hCAFEF00D, 4'hF, M_NONE);
        repeat (3) @(negedge clk);
        check("pre_rst_cyc", WBm_CYC_o, 1'b1);
        @(posedge clk); #3 rst = 1'b1;
        #1;
        check("mid_rst_bus", {WBm_CYC_o, WBm_STB_o, WBm_WE_o, WBm_BYTE_STB_o}, 0);
        check("mid_rst_adr", WBm_ADR_o, 0);
        check("mid_rst_dat", WBm_DAT_o, 0);
        check("mid_rst_rsp", {rsp_valid_o, rsp_err_o, busy_o, err_cnt_o}, 0);
        check("mid_rst_rsp_dat", rsp_dat_o, 0);
        check("mid_rst_cmd_ready", cmd_ready_o, 1'b1);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #2 ack_force = 1;
        @(posedge clk); #2 ack_force = 0;
        repeat (2) @(negedge clk);
        check("spurious_no_rsp", rsp_valid_o, 1'b0);
        check("spurious_idle", busy_o, 1'b0);
        txn(1'b0, 17'h004, 32'h0, 4'hF, M_REG, d, e, nc, ne);
        check("post_rst_dat", d, 32'h12345678);
        check("post_rst_err", e, 1'b0);
        check("post_rst_cyc_cycles", nc, 2);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
